// File: rtl/intersection_pkg.sv
// -----------------------------------------------------------------------------
// intersection_pkg
// Shared definitions for the intersection scheduler:
//   phase_e     - 3-bit phase/state encoding (also driven out on the debug port)
//   phase_load  - maps a phase to the counter value loaded on entry (TIME-1)
// -----------------------------------------------------------------------------
package intersection_pkg;

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5,
        WALK = 3'd6,
        AR3  = 3'd7
    } phase_e;

    // Each timed phase lasts exactly TIME cycles, so the counter starts at TIME-1.
    function automatic int unsigned phase_load(
        input phase_e      s,
        input int unsigned green_t,
        input int unsigned yellow_t,
        input int unsigned allred_t,
        input int unsigned walk_t
    );
        int unsigned v;
        v = allred_t - 1;
        case (s)
            NS_G, EW_G:     v = green_t - 1;
            NS_Y, EW_Y:     v = yellow_t - 1;
            WALK:           v = walk_t - 1;
            AR1, AR2, AR3:  v = allred_t - 1;
            default:        v = allred_t - 1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// -----------------------------------------------------------------------------
// intersection_scheduler_if
// Request inputs and lamp/status outputs of the intersection scheduler.
//   ew_car, ped_req, emerg          : requests into the scheduler
//   ns_*/ew_* lamps, walk           : Moore lamp outputs
//   ped_ack                         : one-cycle pulse at walk start
//   phase                           : current phase encoding (debug)
// slave  = scheduler side, master = environment/sensor side.
// -----------------------------------------------------------------------------
interface intersection_scheduler_if;

    logic       ew_car;
    logic       ped_req;
    logic       emerg;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output ew_car, ped_req, emerg,
        input  ns_red, ns_yellow, ns_green,
        input  ew_red, ew_yellow, ew_green,
        input  walk, ped_ack, phase
    );

    modport slave (
        input  ew_car, ped_req, emerg,
        output ns_red, ns_yellow, ns_green,
        output ew_red, ew_yellow, ew_green,
        output walk, ped_ack, phase
    );

endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter, saturating at zero.
//   clk, rst_n : clock, asynchronous active-low reset (counter -> RST_VAL)
//   load       : load load_val this cycle (takes priority over decrement)
//   load_val   : value loaded on entry into a phase
//   zero       : counter is at zero
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int unsigned      CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
// Two-road intersection sequencer. NS rests in green; EW is served on demand
// from ew_car; pedestrian requests are latched and served in an all-red walk.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : intersection_scheduler_if.slave (requests in, lamps/status out)
//
// Build option: EMERG_PREEMPT_EN - when defined, emerg forces the active road
// (or walk) into clearance and holds all-red while asserted, then resumes at
// NS_G. When undefined, emerg is ignored and no preempt logic exists.
//
// state | meaning
// ------+-------------------------------------------------------------
// NS_G  | NS green; rests here until min green done and a request is seen
// NS_Y  | NS yellow
// AR1   | all-red after NS yellow; next is WALK or EW_G
// EW_G  | EW green, fixed length
// EW_Y  | EW yellow
// AR2   | all-red after EW yellow; next is WALK or NS_G
// WALK  | pedestrian walk, both roads red
// AR3   | all-red after walk; next is EW_G or NS_G
// -----------------------------------------------------------------------------
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int unsigned GREEN_TIME  = 8,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 2,
    parameter int unsigned WALK_TIME   = 6,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    intersection_scheduler_if.slave   bus
);

    phase_e           state;
    phase_e           state_nx;
    logic             ped_pending;
    logic             ped_ack_q;
    logic             enter_walk;
    logic             cnt_zero;
    logic             load;
    logic [CNT_W-1:0] load_val;

`ifdef EMERG_PREEMPT_EN
    logic preempt;
    logic is_ar;
    assign is_ar = (state == AR1) || (state == AR2) || (state == AR3);
`else
    logic emerg_unused;
    assign emerg_unused = bus.emerg;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            NS_G: if (cnt_zero && (bus.ew_car || ped_pending)) state_nx = NS_Y;
            NS_Y: if (cnt_zero) state_nx = AR1;
            AR1:  if (cnt_zero) state_nx = ped_pending ? WALK : EW_G;
            EW_G: if (cnt_zero) state_nx = EW_Y;
            EW_Y: if (cnt_zero) state_nx = AR2;
            AR2:  if (cnt_zero) state_nx = ped_pending ? WALK : NS_G;
            WALK: if (cnt_zero) state_nx = AR3;
            AR3:  if (cnt_zero) state_nx = bus.ew_car ? EW_G : NS_G;
            default: state_nx = NS_G;
        endcase
`ifdef EMERG_PREEMPT_EN
        // Yellow phases always run to completion; everything else yields.
        if (bus.emerg) begin
            case (state)
                NS_G:          state_nx = NS_Y;
                EW_G:          state_nx = EW_Y;
                WALK:          state_nx = AR3;
                AR1, AR2, AR3: state_nx = state;
                default:       ;
            endcase
        end else if (preempt && is_ar && cnt_zero) begin
            state_nx = NS_G;
        end
`endif
    end

    // Every phase change reloads the timer, including a preempted green.
    assign load       = (state_nx != state);
    assign load_val   = CNT_W'(phase_load(state_nx, GREEN_TIME, YELLOW_TIME,
                                           ALLRED_TIME, WALK_TIME));
    assign enter_walk = (state_nx == WALK) && (state != WALK);

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(GREEN_TIME - 1))
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= NS_G;
            ped_pending <= 1'b0;
            ped_ack_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            // A request arriving on the walk-entry cycle is kept for a later walk.
            ped_pending <= bus.ped_req | (ped_pending & ~enter_walk);
            ped_ack_q   <= enter_walk;
        end
    end

`ifdef EMERG_PREEMPT_EN
    // Remembers that the current clearance came from a preempt so the
    // scheduler resumes at NS_G instead of the normal successor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preempt <= 1'b0;
        end else if (state_nx == NS_G) begin
            preempt <= 1'b0;
        end else if (bus.emerg && (state != NS_Y) && (state != EW_Y)) begin
            preempt <= 1'b1;
        end
    end
`endif

    assign bus.ns_green  = (state == NS_G);
    assign bus.ns_yellow = (state == NS_Y);
    assign bus.ns_red    = (state != NS_G) && (state != NS_Y);
    assign bus.ew_green  = (state == EW_G);
    assign bus.ew_yellow = (state == EW_Y);
    assign bus.ew_red    = (state != EW_G) && (state != EW_Y);
    assign bus.walk      = (state == WALK);
    assign bus.ped_ack   = ped_ack_q;
    assign bus.phase     = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_scheduler
// Scoreboard bench: each scenario pushes the expected per-cycle phase sequence,
// then drives stimulus and pops/compares one entry per clock at the falling edge.
// Timing used throughout: GREEN=5, YELLOW=2, ALLRED=1, WALK=4.
// -----------------------------------------------------------------------------
module tb_intersection_scheduler;

    localparam logic [2:0] P_NS_G = 3'd0;
    localparam logic [2:0] P_NS_Y = 3'd1;
    localparam logic [2:0] P_AR1  = 3'd2;
    localparam logic [2:0] P_EW_G = 3'd3;
    localparam logic [2:0] P_EW_Y = 3'd4;
    localparam logic [2:0] P_AR2  = 3'd5;
    localparam logic [2:0] P_WALK = 3'd6;
    localparam logic [2:0] P_AR3  = 3'd7;

    typedef struct packed {
        logic [2:0] ph;
        logic       ack;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    exp_t exp_q[$];

    intersection_scheduler_if bus ();

    intersection_scheduler #(
        .GREEN_TIME  (5),
        .YELLOW_TIME (2),
        .ALLRED_TIME (1),
        .WALK_TIME   (4),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
    function automatic logic [6:0] lamps_of(input logic [2:0] ph);
        logic [6:0] l;
        case (ph)
            P_NS_G:  l = 7'b001_100_0;
            P_NS_Y:  l = 7'b010_100_0;
            P_EW_G:  l = 7'b100_001_0;
            P_EW_Y:  l = 7'b100_010_0;
            P_WALK:  l = 7'b100_100_1;
            default: l = 7'b100_100_0;
        endcase
        return l;
    endfunction

    function automatic logic [6:0] lamps_now();
        return {bus.ns_red, bus.ns_yellow, bus.ns_green,
                bus.ew_red, bus.ew_yellow, bus.ew_green, bus.walk};
    endfunction

    task automatic push(input logic [2:0] ph, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ph  = ph;
            e.ack = (ph == P_WALK) && (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic cycle_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_underrun"}, 32'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_phase"}, 32'(bus.phase),   32'(e.ph));
            check_val({tag, "_lamps"}, 32'(lamps_now()), 32'(lamps_of(e.ph)));
            check_val({tag, "_ack"},   32'(bus.ped_ack), 32'(e.ack));
        end
        @(negedge clk);
    endtask

    task automatic run_seq(input string tag, input int n, input int req_a, input int req_b);
        for (int i = 0; i < n; i++) begin
            bus.ped_req = (i == req_a) || (i == req_b);
            cycle_check(tag);
        end
        bus.ped_req = 1'b0;
        check_val({tag, "_leftover"}, 32'(exp_q.size()), 0);
    endtask

    task automatic do_reset(input logic car);
        rst_n       = 1'b0;
        bus.ew_car  = car;
        bus.ped_req = 1'b0;
        bus.emerg   = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_val("rst_phase", 32'(bus.phase),   32'(P_NS_G));
        check_val("rst_lamps", 32'(lamps_now()), 32'(lamps_of(P_NS_G)));
        check_val("rst_ack",   32'(bus.ped_ack), 0);
        rst_n = 1'b1;
    endtask

    // Lamp safety and one-hot check every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check_val("invariant",
                32'(((bus.ns_green | bus.ns_yellow) & (bus.ew_green | bus.ew_yellow)) |
                    (bus.walk & (bus.ns_green | bus.ew_green)) |
                    ($countones({bus.ns_red, bus.ns_yellow, bus.ns_green}) != 1) |
                    ($countones({bus.ew_red, bus.ew_yellow, bus.ew_green}) != 1)),
                0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.ew_car   = 1'b0;
        bus.ped_req  = 1'b0;
        bus.emerg    = 1'b0;
        @(negedge clk);

        // 1: idle, NS rests in green
        do_reset(1'b0);
        push(P_NS_G, 40);
        run_seq("idle", 40, -1, -1);

        // 2: continuous side-road demand, two full cycles
        do_reset(1'b1);
        for (int k = 0; k < 2; k++) begin
            push(P_NS_G, 5); push(P_NS_Y, 2); push(P_AR1, 1);
            push(P_EW_G, 5); push(P_EW_Y, 2); push(P_AR2, 1);
        end
        push(P_NS_G, 3);
        run_seq("car", 35, -1, -1);

        // 3: single pedestrian pulse, no cars
        do_reset(1'b0);
        push(P_NS_G, 5); push(P_NS_Y, 2); push(P_AR1, 1);
        push(P_WALK, 4); push(P_AR3, 1); push(P_NS_G, 8);
        run_seq("ped", 21, 2, -1);

        // 4: ped during EW_G, then another during WALK
        do_reset(1'b1);
        push(P_NS_G, 5); push(P_NS_Y, 2); push(P_AR1, 1);
        push(P_EW_G, 5); push(P_EW_Y, 2); push(P_AR2, 1);
        push(P_WALK, 4); push(P_AR3, 1);
        push(P_EW_G, 5); push(P_EW_Y, 2); push(P_AR2, 1);
        push(P_WALK, 4); push(P_AR3, 1); push(P_EW_G, 2);
        run_seq("ped2", 36, 9, 17);

        // 5: reset in the middle of EW_Y drops the pending request
        do_reset(1'b1);
        push(P_NS_G, 5); push(P_NS_Y, 2); push(P_AR1, 1);
        push(P_EW_G, 5); push(P_EW_Y, 1);
        run_seq("prerst", 14, 9, -1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_phase", 32'(bus.phase),   32'(P_NS_G));
        check_val("midrst_lamps", 32'(lamps_now()), 32'(lamps_of(P_NS_G)));
        check_val("midrst_ack",   32'(bus.ped_ack), 0);
        @(negedge clk);
        bus.ew_car = 1'b0;
        rst_n      = 1'b1;
        push(P_NS_G, 15);
        run_seq("postrst", 15, -1, -1);

`ifdef EMERG_PREEMPT_EN
        // 6: emergency during EW_G, held through all-red, release to NS_G
        do_reset(1'b1);
        push(P_NS_G, 5); push(P_NS_Y, 2); push(P_AR1, 1);
        push(P_EW_G, 2); push(P_EW_Y, 2); push(P_AR2, 6); push(P_NS_G, 8);
        for (int i = 0; i < 26; i++) begin
            bus.emerg  = (i >= 9) && (i <= 16);
            bus.ew_car = (i < 17);
            cycle_check("emerg");
        end
        bus.emerg = 1'b0;
        check_val("emerg_leftover", 32'(exp_q.size()), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
